// File: rtl/mem_seq.sv
// mem_seq: MEM-stage memory sequencer. Splits a 32-bit access into up to two
// 16-bit beats on a req/ack bus, holds the pipeline until it completes and
// presents the merged read word in DONE.
// Optional feature macro: MEM_SEQ_TIMEOUT_EN (per-beat ack timeout, bus_err_o).
module mem_seq #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        sel_i,
    output logic [31:0]       rdata_o,
    output logic              stallreq_o,
    output logic [1:0]        cnt_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [15:0]       bus_wdata_o,
    output logic [1:0]        bus_be_o,
    input  logic              bus_ack_i,
    input  logic [15:0]       bus_rdata_i,
    output logic              bus_err_o
);

    typedef enum logic [2:0] {StIdle, StLo, StHi, StDone, StDrain} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic              hi_q, hi_d;      // current beat is the upper halfword
    logic [ADDR_W-2:0] baddr_q, baddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack;
    logic              tmo;

    assign bus_req_o = (state_q == StLo) || (state_q == StHi) || (state_q == StDrain);
    assign ack       = bus_req_o & bus_ack_i;

    // Reset gating keeps every output at 0 while rst is held.
    assign stallreq_o = req_i & ~rst & (state_q != StDone);

    // Bus fields are driven only while a beat is outstanding.
    assign bus_we_o    = bus_req_o & we_q;
    assign bus_addr_o  = bus_req_o ? {baddr_q, hi_q} : '0;
    assign bus_wdata_o = !bus_req_o ? 16'h0 : (hi_q ? wdata_q[31:16] : wdata_q[15:0]);
    assign bus_be_o    = !bus_req_o ? 2'b00 : (hi_q ? sel_q[3:2] : sel_q[1:0]);
    assign rdata_o     = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:ADDR_W+1], addr_i[1:0], stall[5], stall[3:0]};

`ifdef MEM_SEQ_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;

    assign tmo       = bus_req_o && !bus_ack_i && (wait_q == 8'(TIMEOUT - 1));
    assign bus_err_o = tmo;

    // Wait counter: restarts on each new beat, counts unacknowledged request cycles.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q && (state_d == StLo || state_d == StHi)) begin
            wait_d = '0;
        end else if (bus_req_o && !bus_ack_i) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign tmo            = 1'b0;
    assign bus_err_o      = 1'b0;
`endif

    // Phase code seen by the MEM/WB register.
    always_comb begin
        cnt_o = 2'b00;
        case (state_q)
            StLo:    cnt_o = 2'b01;
            StHi:    cnt_o = 2'b10;
            StDone:  cnt_o = 2'b11;
            default: cnt_o = 2'b00;
        endcase
    end

    // Next-state, request latching and read-data merge.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        hi_d    = hi_q;
        baddr_d = baddr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (!flush && req_i) begin
                    we_d    = we_i;
                    baddr_d = addr_i[ADDR_W:2];
                    wdata_d = wdata_i;
                    sel_d   = sel_i;
                    rdata_d = '0;
                    if (|sel_i[1:0]) begin
                        state_d = StLo;
                        hi_d    = 1'b0;
                    end else if (|sel_i[3:2]) begin
                        state_d = StHi;
                        hi_d    = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLo, StHi: begin
                if (flush) begin
                    // A beat that completes or expires with the flush needs no drain.
                    state_d = (ack || tmo) ? StIdle : StDrain;
                end else if (ack) begin
                    if (!we_q) begin
                        if (hi_q) begin
                            rdata_d[31:16] = bus_rdata_i;
                        end else begin
                            rdata_d[15:0] = bus_rdata_i;
                        end
                    end
                    if (!hi_q && (|sel_q[3:2])) begin
                        state_d = StHi;
                        hi_d    = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else if (tmo) begin
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (flush || !stall[4]) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (ack || tmo) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            hi_q    <= 1'b0;
            baddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            hi_q    <= hi_d;
            baddr_q <= baddr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- MEM-stage multi-cycle memory sequencer.
- Splits each 32-bit load/store from the MEM stage into up to two 16-bit beats on an external req/ack bus. Holds the pipeline with stallreq_o until the access completes, then presents the merged read word.
- Reports its phase on cnt_o, which feeds the 2-bit cnt_i port of the MEM/WB register.

Parameters:
ADDR_W, 20, external halfword bus address width.
TIMEOUT, 255, max cycles a beat may wait for bus_ack_i (used only with MEM_SEQ_TIMEOUT_EN).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high (1 = reset).
stall  in  6  pipeline stall vector; bit 4 = MEM/WB stop.
flush  in  1  pipeline flush.
req_i  in  1  MEM stage has a memory access.
we_i  in  1  1 = store, 0 = load.
addr_i  in  32  byte address (word-aligned).
wdata_i  in  32  store data.
sel_i  in  4  byte enables.
rdata_o  out  32  merged load data; valid in DONE.
stallreq_o  out  1  stall request to pipeline control (combinational).
cnt_o  out  2  phase: IDLE=00, LO=01, HI=10, DONE=11, DRAIN=00.
bus_req_o  out  1  beat request.
bus_we_o  out  1  beat write.
bus_addr_o  out  ADDR_W  halfword address.
bus_wdata_o  out  16  beat write data.
bus_be_o  out  2  beat byte enables.
bus_ack_i  in  1  beat complete; sampled at posedge.
bus_rdata_i  in  16  read data, valid with bus_ack_i.
bus_err_o  out  1  timeout pulse (feature only; else tied 0).

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs and internal registers = 0.
- IDLE, req_i=1: latch we/addr/wdata/sel; clear rdata_o.
  - sel[1:0]!=0 -> LO.
  - else sel[3:2]!=0 -> HI.
  - else (sel=0000) -> DONE; no bus activity.
- LO beat:
  - Bus fields: bus_addr_o={addr[ADDR_W:2],1'b0}, bus_wdata_o=wdata[15:0], bus_be_o=sel[1:0].
  - On ack: rdata_o[15:0]<=bus_rdata_i (loads only); then -> HI if sel[3:2]!=0, else DONE.
- HI beat:
  - Bus fields: addr LSB=1, wdata[31:16], be=sel[3:2].
  - On ack: rdata_o[31:16]<=bus_rdata_i; -> DONE.
- Skipped halves read as 0.
- bus_req_o is 1 exactly in LO, HI and DRAIN. Address, data, be and we are stable while req is high. Back-to-back beats are allowed: LO ack -> HI request on the next cycle. An ack while bus_req_o=0 is ignored.
- stallreq_o = req_i & (state in IDLE, LO, HI, DRAIN).
  - stallreq_o is 0 in DONE.
  - stallreq_o is 0 in IDLE when req_i=0.
- DONE:
  - stall[4]=0 -> IDLE next cycle.
  - stall[4]=1 (downstream stall) -> hold DONE, rdata_o stable.
- Flush (lower priority than rst):
  - In IDLE or DONE -> IDLE.
  - In LO/HI -> DRAIN. The outstanding beat keeps req high until ack; ack in DRAIN -> IDLE; no data captured; no DONE.
  - A flush arriving while already in DRAIN has no further effect.
  - Flush and ack in the same cycle in LO/HI -> IDLE directly.
- Latched fields ignore changes on *_i after acceptance.
- Async reset mid-beat: bus_req_o drops immediately. The bus side must tolerate an abandoned beat.

Optional Feature:
- Macro: MEM_SEQ_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on each beat start and counts each cycle bus_req_o=1 without ack.
  - On reaching TIMEOUT: bus_err_o pulses 1 cycle, remaining beats are skipped, rdata_o<=0, -> DONE. From DRAIN, the timeout goes -> IDLE instead.
- Undefined: no counter, bus_err_o=0, a beat waits forever.

Test Plan:
- Load, addr 0x0000_1004, sel 1111, ack 2 cycles after each req, bus data 0xBEEF then 0xDEAD:
  - bus_addr 0x00802 then 0x00803.
  - rdata_o=0xDEADBEEF in DONE.
  - cnt_o 01,01,01,10,10,10,11.
  - stallreq_o low only in DONE.
- Store sel 1100, wdata 0x12345678, immediate ack: single HI beat, be=11, wdata=0x1234, we=1; LO beat never issued.
- Flush in LO before ack, ack 3 cycles later: DRAIN holds req until ack, then IDLE; done never reached, rdata_o=0.
- DONE with stall[4]=1 for 4 cycles: state and rdata_o held, stallreq_o=0, then IDLE when stall[4]=0.
- rst asserted mid-HI beat: all outputs 0 asynchronously, before the next clock edge.
- (MEM_SEQ_TIMEOUT_EN, TIMEOUT=8) ack never arrives in LO: bus_err_o pulses on the 8th waiting cycle, HI skipped, DONE with rdata_o=0.
